// File: rtl/spi_master_cfg_pkg.sv
// Shared types and helpers for the configurable SPI master: FSM states,
// SPI mode encodings and derived field widths.
package spi_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int cs_idx_w(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

    function automatic int edge_cnt_w(input int data_w);
        return $clog2(2 * data_w + 1);
    endfunction

endpackage

// File: rtl/spi_master_cfg_clk_gen.sv
// SCLK timing: H-cycle down-counter producing a tick per half-period, plus
// leading/trailing edge strobes and a running edge count.
module spi_clk_gen
    import spi_cfg_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8,
    localparam int EW    = edge_cnt_w(DATA_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             run_i,
    input  logic             edge_en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o,
    output logic             lead_edge_o,
    output logic             trail_edge_o,
    output logic [EW-1:0]    edge_cnt_o
);

    localparam logic [EW-1:0] NUM_EDGES = EW'(2 * DATA_W);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q;
    logic [EW-1:0]    edge_q, edge_d;
    logic             edge_stb;

    assign tick_o       = run_i && (cnt_q == '0);
    assign edge_stb     = tick_o && edge_en_i && (edge_q != NUM_EDGES);
    assign lead_edge_o  = edge_stb && !edge_q[0];
    assign trail_edge_o = edge_stb &&  edge_q[0];
    assign edge_cnt_o   = edge_q;

    always_comb begin
        cnt_d  = cnt_q;
        edge_d = edge_q;
        if (load_i) begin
            cnt_d  = div_i;
            edge_d = '0;
        end else if (run_i) begin
            cnt_d = tick_o ? div_q : cnt_q - 1'b1;
            if (edge_stb) edge_d = edge_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            div_q  <= '0;
            edge_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            edge_q <= edge_d;
            if (load_i) div_q <= div_i;
        end
    end

endmodule

// File: rtl/spi_master_cfg.sv
// Configurable SPI master: DATA_W-bit frames, MSB first, all four CPOL/CPHA
// modes, runtime SCLK divider and one-hot active-low chip selects.
module spi_master_cfg
    import spi_cfg_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 2,
    parameter int DIV_W  = 8,
    localparam int CSW   = cs_idx_w(NUM_CS),
    localparam int EW    = edge_cnt_w(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [CSW-1:0]    cs_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);

    localparam logic [EW-1:0] NUM_EDGES = EW'(2 * DATA_W);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    state_e state_q, state_d;
    logic   accept, finish;

    logic          tick, lead_edge, trail_edge;
    logic [EW-1:0] edge_cnt;

    logic [1:0]        mode_q;
    logic              samp_lead;
    logic              shift_evt, samp_evt;
    logic [DATA_W-1:0] tx_sh_q, rx_sh_q, rx_data_q;
    logic              sclk_q, mosi_q, done_q;
    logic [NUM_CS-1:0] cs_n_q, cs_dec;

    spi_clk_gen #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W)
    ) u_clk_gen (
        .clk          (clk),
        .reset        (reset),
        .load_i       (accept),
        .run_i        (state_q != IDLE),
        .edge_en_i    ((state_q == SETUP) || (state_q == XFER)),
        .div_i        (clk_div),
        .tick_o       (tick),
        .lead_edge_o  (lead_edge),
        .trail_edge_o (trail_edge),
        .edge_cnt_o   (edge_cnt)
    );

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    accept  = 1'b1;
                end
            end
            SETUP: if (tick) state_d = XFER;
            XFER:  if (tick && (edge_cnt == NUM_EDGES)) state_d = HOLD;
            HOLD: begin
                if (tick) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // CPHA=0 modes sample on the leading edge, CPHA=1 modes on the trailing edge.
    always_comb begin
        samp_lead = 1'b1;
        unique case (mode_q)
            MODE0, MODE2: samp_lead = 1'b1;
            MODE1, MODE3: samp_lead = 1'b0;
            default:      samp_lead = 1'b1;
        endcase
    end

    // With CPHA=0 the MSB is already on MOSI, so the final trailing edge must not shift.
    assign shift_evt = samp_lead ? (trail_edge && (edge_cnt != LAST_EDGE)) : lead_edge;
    assign samp_evt  = samp_lead ? lead_edge : trail_edge;

    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_sel == CSW'(i)) cs_dec[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q    <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_n_q    <= '1;
        end else begin
            done_q <= finish;
            if (state_q == IDLE) begin
                sclk_q <= cpol;
                if (accept) begin
                    mode_q  <= {cpol, cpha};
                    cs_n_q  <= cs_dec;
                    rx_sh_q <= '0;
                    if (cpha) tx_sh_q <= tx_data;
                    else      {mosi_q, tx_sh_q} <= {tx_data, 1'b0};
                end
            end else begin
                if (lead_edge || trail_edge) sclk_q <= ~sclk_q;
                if (shift_evt) {mosi_q, tx_sh_q} <= {tx_sh_q, 1'b0};
                if (samp_evt)  rx_sh_q <= {rx_sh_q[DATA_W-2:0], miso};
                if (finish) begin
                    cs_n_q    <= '1;
                    rx_data_q <= rx_sh_q;
                end
            end
        end
    end

    assign rx_data = rx_data_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg: an 8-bit/2-CS instance with loopback or a
// shift-register slave, and a 16-bit/5-CS instance for out-of-range select.
module tb_spi_master_cfg;
    import spi_cfg_pkg::*;

    localparam logic [7:0] SLAVE_WORD = 8'h96;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b0;

    // 8-bit instance
    logic       start8 = 1'b0, cpol8 = 1'b0, cpha8 = 1'b0;
    logic [7:0] div8 = '0, tx8 = '0;
    logic [0:0] sel8 = '0;
    logic [7:0] rx8;
    logic       busy8, done8, sclk8, mosi8, miso8;
    logic [1:0] cs8;

    // 16-bit instance
    logic        start16 = 1'b0;
    logic [7:0]  div16 = '0;
    logic [2:0]  sel16 = '0;
    logic [15:0] tx16 = '0;
    logic [15:0] rx16;
    logic        busy16, done16, sclk16, mosi16;
    logic [4:0]  cs16;

    spi_master_cfg #(.DATA_W(8), .NUM_CS(2), .DIV_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .cpol(cpol8), .cpha(cpha8),
        .clk_div(div8), .cs_sel(sel8), .tx_data(tx8), .rx_data(rx8),
        .busy(busy8), .done(done8), .sclk(sclk8), .mosi(mosi8), .miso(miso8),
        .cs_n(cs8)
    );

    spi_master_cfg #(.DATA_W(16), .NUM_CS(5), .DIV_W(8)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16), .cpol(1'b0), .cpha(1'b0),
        .clk_div(div16), .cs_sel(sel16), .tx_data(tx16), .rx_data(rx16),
        .busy(busy16), .done(done16), .sclk(sclk16), .mosi(mosi16), .miso(mosi16),
        .cs_n(cs16)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Shift-register slave model; loopback when disabled
    logic       slave_en = 1'b0;
    logic       sl_miso = 1'b0;
    logic [7:0] sl_tx = '0, sl_rx = '0;
    int         sl_unstable = 0;
    logic [1:0] cs_prev = 2'b11;
    logic       sclk_prev = 1'b0;
    logic       mosi_neg = 1'b0;

    assign miso8 = slave_en ? sl_miso : mosi8;

    always @(negedge clk) mosi_neg = mosi8;

    always @(cs8, sclk8) begin
        if (cs8 != cs_prev) begin
            if (cs8 != 2'b11 && cs_prev == 2'b11) begin
                sl_tx = SLAVE_WORD;
                sl_rx = '0;
                sl_unstable = 0;
                if (!cpha8) begin
                    sl_miso = sl_tx[7];
                    sl_tx   = {sl_tx[6:0], 1'b0};
                end
            end
            cs_prev = cs8;
        end
        if (sclk8 != sclk_prev) begin
            if (cs8 != 2'b11) begin
                if ((sclk8 != cpol8) ^ cpha8) begin
                    sl_rx = {sl_rx[6:0], mosi8};
                    if (mosi8 !== mosi_neg) sl_unstable++;
                end else begin
                    sl_miso = sl_tx[7];
                    sl_tx   = {sl_tx[6:0], 1'b0};
                end
            end
            sclk_prev = sclk8;
        end
    end

    int   r_busy, r_edges, r_done, r_csbad, r_gmin, r_gmax, r_rxchg;
    logic r_idle;

    // One transfer on the 8-bit instance; extra >= 0 pulses start again at that cycle.
    task automatic run8(input logic [1:0] mode, input logic [7:0] div, input logic sel,
                        input logic [7:0] tx, input int extra);
        int         budget, gap;
        logic       prev, seen_done;
        logic [7:0] rx_before;
        logic [1:0] exp_cs;
        budget = 18 * (int'(div) + 1) + 12;
        exp_cs = sel ? 2'b01 : 2'b10;
        @(negedge clk);
        {cpol8, cpha8} = mode;
        div8 = div;
        sel8 = sel;
        tx8  = tx;
        @(negedge clk);
        @(negedge clk);
        r_idle    = sclk8;
        rx_before = rx8;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        r_busy = 0; r_edges = 0; r_done = 0; r_csbad = 0; r_rxchg = 0;
        r_gmin = 1000; r_gmax = 0; gap = 0;
        prev = sclk8;
        seen_done = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            start8 = (cyc == extra);
            if (busy8) r_busy++;
            if (done8) begin
                r_done++;
                seen_done = 1'b1;
            end
            if (busy8 && cs8 !== exp_cs) r_csbad++;
            if (!seen_done && rx8 !== rx_before) r_rxchg++;
            if (sclk8 !== prev) begin
                r_edges++;
                if (r_edges > 1) begin
                    if (gap < r_gmin) r_gmin = gap;
                    if (gap > r_gmax) r_gmax = gap;
                end
                gap = 0;
            end
            gap++;
            prev = sclk8;
            @(negedge clk);
        end
        start8 = 1'b0;
    endtask

    initial begin
        int c_busy, c_edges, c_done, c_cslow;

        #2 reset = 1'b1;
        #1;
        check("rst_rx",   32'(rx8),   32'h0);
        check("rst_busy", 32'(busy8), 32'h0);
        check("rst_done", 32'(done8), 32'h0);
        check("rst_sclk", 32'(sclk8), 32'h0);
        check("rst_mosi", 32'(mosi8), 32'h0);
        check("rst_cs_n", 32'(cs8),   32'h3);
        check("rst_cs16", 32'(cs16),  32'h1f);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Mode 0 loopback, H=1
        run8(MODE0, 8'd0, 1'b0, 8'hA5, -1);
        check("m0_idle",  32'(r_idle), 32'h0);
        check("m0_busy",  r_busy,  18);
        check("m0_edges", r_edges, 16);
        check("m0_gmin",  r_gmin,  1);
        check("m0_gmax",  r_gmax,  1);
        check("m0_cs",    r_csbad, 0);
        check("m0_done",  r_done,  1);
        check("m0_rxstb", r_rxchg, 0);
        check("m0_rx",    32'(rx8), 32'hA5);
        check("m0_csend", 32'(cs8), 32'h3);

        // Mode 3 loopback, H=4
        run8(MODE3, 8'd3, 1'b1, 8'h3C, -1);
        check("m3_idle",  32'(r_idle), 32'h1);
        check("m3_busy",  r_busy,  72);
        check("m3_edges", r_edges, 16);
        check("m3_gmin",  r_gmin,  4);
        check("m3_gmax",  r_gmax,  4);
        check("m3_cs",    r_csbad, 0);
        check("m3_done",  r_done,  1);
        check("m3_rx",    32'(rx8), 32'h3C);

        // Modes 1 and 2 against the slave model
        slave_en = 1'b1;
        run8(MODE1, 8'd1, 1'b0, 8'h5A, -1);
        check("m1_busy",   r_busy, 36);
        check("m1_done",   r_done, 1);
        check("m1_rx",     32'(rx8), 32'(SLAVE_WORD));
        check("m1_slv_rx", 32'(sl_rx), 32'h5A);
        check("m1_stable", sl_unstable, 0);
        run8(MODE2, 8'd2, 1'b1, 8'hC3, -1);
        check("m2_idle",   32'(r_idle), 32'h1);
        check("m2_busy",   r_busy, 54);
        check("m2_done",   r_done, 1);
        check("m2_rx",     32'(rx8), 32'(SLAVE_WORD));
        check("m2_slv_rx", 32'(sl_rx), 32'hC3);
        check("m2_stable", sl_unstable, 0);
        slave_en = 1'b0;

        // Start while busy is ignored; a fresh start from IDLE runs normally
        run8(MODE0, 8'd1, 1'b0, 8'h69, 5);
        check("ign_busy", r_busy, 36);
        check("ign_done", r_done, 1);
        check("ign_rx",   32'(rx8), 32'h69);
        run8(MODE0, 8'd0, 1'b1, 8'h17, -1);
        check("re_done",  r_done, 1);
        check("re_rx",    32'(rx8), 32'h17);

        // Reset mid-transfer
        @(negedge clk);
        {cpol8, cpha8} = MODE3;
        div8 = 8'd1;
        sel8 = 1'b0;
        tx8  = 8'hF0;
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_busy", 32'(busy8), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("mid_cs_n", 32'(cs8),   32'h3);
        check("mid_busy0", 32'(busy8), 32'h0);
        check("mid_sclk", 32'(sclk8), 32'h0);
        check("mid_rx",   32'(rx8),   32'h0);
        check("mid_done", 32'(done8), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        c_done = 0;
        c_busy = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (done8) c_done++;
            if (busy8) c_busy++;
            @(negedge clk);
        end
        check("post_done", c_done, 0);
        check("post_busy", c_busy, 0);

        // 16-bit frame, out-of-range chip select, loopback
        sel16 = 3'd5;
        tx16  = 16'hBEEF;
        div16 = 8'd0;
        @(negedge clk);
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        c_busy = 0; c_edges = 0; c_done = 0; c_cslow = 0;
        begin
            logic prev16;
            prev16 = sclk16;
            for (int cyc = 0; cyc < 46; cyc++) begin
                if (busy16) c_busy++;
                if (done16) c_done++;
                if (cs16 !== 5'h1f) c_cslow++;
                if (sclk16 !== prev16) c_edges++;
                prev16 = sclk16;
                @(negedge clk);
            end
        end
        check("w16_busy",  c_busy,  34);
        check("w16_edges", c_edges, 32);
        check("w16_cs",    c_cslow, 0);
        check("w16_done",  c_done,  1);
        check("w16_rx",    32'(rx16), 32'hBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
